// File: rtl/decode_read.sv
// decode_read: selects Y86-64 source/destination registers, reads operands with write-back bypass,
// and holds the result in a single-entry valid/ready output stage.
module decode_read #(
  parameter int DW   = 64,
  parameter int NREG = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           icode,
  input  logic [3:0]           ifun,
  input  logic [3:0]           rA,
  input  logic [3:0]           rB,
  input  logic [NREG*DW-1:0]   regs_flat,
  input  logic                 wbE_en,
  input  logic [3:0]           wbE_dst,
  input  logic [DW-1:0]        wbE_val,
  input  logic                 wbM_en,
  input  logic [3:0]           wbM_dst,
  input  logic [DW-1:0]        wbM_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_icode,
  output logic [3:0]           out_ifun,
  output logic [3:0]           srcA,
  output logic [3:0]           srcB,
  output logic [3:0]           dstE,
  output logic [3:0]           dstM,
  output logic [DW-1:0]        valA,
  output logic [DW-1:0]        valB,
  output logic                 out_err
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;
  logic [DW-1:0] w_regs [16];
  logic [3:0]    w_src_a, w_src_b, w_dst_e, w_dst_m;
  logic          w_err;
  logic [DW-1:0] w_val_a, w_val_b;
  for (genvar g = 0; g < 16; g++) begin : g_r
    if (g < NREG) begin : g_v
      assign w_regs[g] = regs_flat[g*DW +: DW];
    end else begin : g_z
      assign w_regs[g] = '0;
    end
  end
  always_comb begin
    w_src_a = RNONE;
    w_src_b = RNONE;
    w_dst_e = RNONE;
    w_dst_m = RNONE;
    w_err   = icode > 4'hB;
    case (icode)
      4'h2: begin w_src_a = rA; w_dst_e = rB; end
      4'h3: w_dst_e = rB;
      4'h4: begin w_src_a = rA; w_src_b = rB; end
      4'h5: begin w_src_b = rB; w_dst_m = rA; end
      4'h6: begin w_src_a = rA; w_src_b = rB; w_dst_e = rB; end
      4'h8: begin w_src_b = RSP; w_dst_e = RSP; end
      4'h9: begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; end
      4'hA: begin w_src_a = rA; w_src_b = RSP; w_dst_e = RSP; end
      4'hB: begin w_src_a = RSP; w_src_b = RSP; w_dst_e = RSP; w_dst_m = rA; end
      default: ;
    endcase
  end
  // A source of F never reaches the bypass compare, so an F write-back destination cannot match.
  function automatic logic [DW-1:0] f_read(input logic [3:0] s);
    return (s == RNONE) ? '0 :
           (wbM_en && wbM_dst == s) ? wbM_val :
           (wbE_en && wbE_dst == s) ? wbE_val : w_regs[s];
  endfunction
  assign w_val_a  = f_read(w_src_a);
  assign w_val_b  = f_read(w_src_b);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_icode <= '0;
      out_ifun  <= '0;
      srcA      <= RNONE;
      srcB      <= RNONE;
      dstE      <= RNONE;
      dstM      <= RNONE;
      valA      <= '0;
      valB      <= '0;
      out_err   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_icode <= icode;
        out_ifun  <= ifun;
        srcA      <= w_src_a;
        srcB      <= w_src_b;
        dstE      <= w_dst_e;
        dstM      <= w_dst_m;
        valA      <= w_val_a;
        valB      <= w_val_b;
        out_err   <= w_err;
      end
    end
  end
endmodule
